// File: rtl/step_arbiter.sv
// ---------------------------------------------------------------------------
// step_arbiter
//
// Schedules steps for the shared counter bank of the display datapath
// (up counter, down counter and the sum register that adds them).
//
// Three requesters compete for one counter step per cycle:
//   0 = up   (req_up key-edge pulse)
//   1 = dn   (req_dn key-edge pulse)
//   2 = auto (prescaler tick, only honoured while in AUTO mode)
// Each requester can hold one pending request. Grants are issued
// round-robin. Every step is followed one cycle later by a sum_load strobe,
// so the sum register always captures a settled counter pair.
//
// Handshake: there is no backpressure. A request is a single-cycle pulse.
// It is either granted that cycle, or parked in the requester's pending
// flag. If a new pulse arrives while that flag is already set and the
// requester is not granted, the pulse is lost and drop_cnt counts it.
//
// Parameters:
//   DROP_W    width of the saturating dropped-request counter
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   req_up    one-cycle request for an up-counter step
//   req_dn    one-cycle request for a down-counter step
//   mode_tgl  one-cycle pulse that toggles MANUAL/AUTO
//   tick      one-cycle prescaler pulse, the auto-step source in AUTO
//   up_en     registered one-cycle enable to the up counter
//   dn_en     registered one-cycle enable to the down counter
//   sum_load  registered one-cycle load strobe for the sum register
//   auto_on   high while in AUTO (also exposes the mode FSM state)
//   busy      high while any pending flag is set
//   drop_cnt  saturating count of lost requests
// ---------------------------------------------------------------------------
module step_arbiter #(
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_up,
    input  logic              req_dn,
    input  logic              mode_tgl,
    input  logic              tick,
    output logic              up_en,
    output logic              dn_en,
    output logic              sum_load,
    output logic              auto_on,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } mode_t;

    localparam logic [DROP_W+1:0] DROP_MAX = {2'b00, {DROP_W{1'b1}}};

    mode_t             state_q, state_d;
    logic [2:0]        pend_q, pend_d;
    logic [1:0]        rr_q, rr_d;
    logic              auto_dir_q, auto_dir_d;
    logic              up_en_q, up_en_d;
    logic              dn_en_q, dn_en_d;
    logic              sum_load_q, sum_load_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic [2:0]        new_req;
    logic [2:0]        eff_req;
    logic [2:0]        grant;
    logic [2:0]        dropped;
    logic [1:0]        drop_n;
    logic [DROP_W+1:0] drop_sum;

    // ------------------------------------------------------------------
    // Request collection. The tick only counts while the current state is
    // AUTO. A mode_tgl in the same cycle does not change that decision.
    // ------------------------------------------------------------------
    always_comb begin
        new_req    = 3'b000;
        new_req[0] = req_up;
        new_req[1] = req_dn;
        new_req[2] = tick & (state_q == AUTO);
        eff_req    = pend_q | new_req;
    end

    // ------------------------------------------------------------------
    // Round-robin grant. The search starts at rr_q and wraps around. At
    // most one grant is issued.
    // ------------------------------------------------------------------
    always_comb begin
        grant = 3'b000;
        case (rr_q)
            2'd0: begin
                if (eff_req[0])      grant = 3'b001;
                else if (eff_req[1]) grant = 3'b010;
                else if (eff_req[2]) grant = 3'b100;
            end
            2'd1: begin
                if (eff_req[1])      grant = 3'b010;
                else if (eff_req[2]) grant = 3'b100;
                else if (eff_req[0]) grant = 3'b001;
            end
            default: begin
                if (eff_req[2])      grant = 3'b100;
                else if (eff_req[0]) grant = 3'b001;
                else if (eff_req[1]) grant = 3'b010;
            end
        endcase
    end

    // Pointer moves just past the winner. It holds when nobody is granted.
    always_comb begin
        rr_d = rr_q;
        if (grant[0])      rr_d = 2'd1;
        else if (grant[1]) rr_d = 2'd2;
        else if (grant[2]) rr_d = 2'd0;
    end

    // ------------------------------------------------------------------
    // Mode FSM: MANUAL <-> AUTO on each mode_tgl pulse.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (mode_tgl) begin
            state_d = (state_q == AUTO) ? MANUAL : AUTO;
        end
    end

    // ------------------------------------------------------------------
    // Pending flags and drop detection.
    //
    // A granted requester keeps its flag only if a fresh pulse arrived
    // alongside an already-pending one. That fresh pulse becomes the next
    // pending request.
    //
    // Leaving AUTO discards the parked auto request. A grant made in the
    // same cycle still issues its enable.
    // ------------------------------------------------------------------
    always_comb begin
        pend_d = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (grant[i]) begin
                pend_d[i] = pend_q[i] & new_req[i];
            end else begin
                pend_d[i] = eff_req[i];
            end
        end
        if (mode_tgl && (state_q == AUTO)) begin
            pend_d[2] = 1'b0;
        end
    end

    always_comb begin
        dropped  = ~grant & pend_q & new_req;
        drop_n   = {1'b0, dropped[0]} + {1'b0, dropped[1]} + {1'b0, dropped[2]};
        drop_sum = {2'b00, drop_q} + {{DROP_W{1'b0}}, drop_n};
        drop_d   = drop_q;
        if (drop_sum > DROP_MAX) begin
            drop_d = {DROP_W{1'b1}};
        end else begin
            drop_d = drop_sum[DROP_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Step outputs. An auto step alternates between the up and down
    // counters. auto_dir survives mode changes, so re-entering AUTO resumes
    // the alternation where it stopped.
    // ------------------------------------------------------------------
    always_comb begin
        up_en_d    = grant[0] | (grant[2] & ~auto_dir_q);
        dn_en_d    = grant[1] | (grant[2] &  auto_dir_q);
        auto_dir_d = auto_dir_q ^ grant[2];
        // The counters update on the cycle that the enable is high. The sum
        // register therefore loads one cycle after that.
        sum_load_d = up_en_q | dn_en_q;
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= MANUAL;
            pend_q     <= 3'b000;
            rr_q       <= 2'd0;
            auto_dir_q <= 1'b0;
            up_en_q    <= 1'b0;
            dn_en_q    <= 1'b0;
            sum_load_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            rr_q       <= rr_d;
            auto_dir_q <= auto_dir_d;
            up_en_q    <= up_en_d;
            dn_en_q    <= dn_en_d;
            sum_load_q <= sum_load_d;
            drop_q     <= drop_d;
        end
    end

    assign up_en    = up_en_q;
    assign dn_en    = dn_en_q;
    assign sum_load = sum_load_q;
    assign auto_on  = (state_q == AUTO);
    assign busy     = |pend_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_step_arbiter.sv
module tb_step_arbiter;

  logic       clk;
  logic       rst;
  logic       req_up, req_dn, mode_tgl, tick;
  logic       up_en, dn_en, sum_load, auto_on, busy;
  logic [7:0] drop_cnt;
  logic       up_en2, dn_en2, sum_load2, auto_on2, busy2;
  logic [1:0] drop_cnt2;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_p[3];
  int m_rr;
  bit m_auto, m_dir;
  int m_drops;
  bit m_up, m_dn, m_sum;

  logic [1:0] exp_q[$];

  step_arbiter dut (
    .clk(clk), .rst(rst), .req_up(req_up), .req_dn(req_dn),
    .mode_tgl(mode_tgl), .tick(tick), .up_en(up_en), .dn_en(dn_en),
    .sum_load(sum_load), .auto_on(auto_on), .busy(busy), .drop_cnt(drop_cnt)
  );

  step_arbiter #(.DROP_W(2)) dut2 (
    .clk(clk), .rst(rst), .req_up(req_up), .req_dn(req_dn),
    .mode_tgl(mode_tgl), .tick(tick), .up_en(up_en2), .dn_en(dn_en2),
    .sum_load(sum_load2), .auto_on(auto_on2), .busy(busy2), .drop_cnt(drop_cnt2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_p[i] = 1'b0;
    m_rr = 0; m_auto = 0; m_dir = 0; m_drops = 0;
    m_up = 0; m_dn = 0; m_sum = 0;
  endtask

  task automatic model_step(input bit u, input bit d, input bit m, input bit t);
    bit nw[3];
    bit want[3];
    int g;
    nw[0] = u; nw[1] = d; nw[2] = t && m_auto;
    for (int i = 0; i < 3; i++) want[i] = m_p[i] | nw[i];
    g = -1;
    for (int k = 0; k < 3; k++) begin
      if (g < 0 && want[(m_rr + k) % 3]) g = (m_rr + k) % 3;
    end
    m_sum = m_up | m_dn;
    m_up = 0; m_dn = 0;
    if (g == 0) m_up = 1;
    if (g == 1) m_dn = 1;
    if (g == 2) begin
      if (m_dir) m_dn = 1; else m_up = 1;
      m_dir = ~m_dir;
    end
    for (int i = 0; i < 3; i++) begin
      if (i == g) m_p[i] = m_p[i] & nw[i];
      else begin
        if (m_p[i] && nw[i]) m_drops++;
        m_p[i] = want[i];
      end
    end
    if (g >= 0) m_rr = (g + 1) % 3;
    if (m) begin
      if (m_auto) m_p[2] = 1'b0;
      m_auto = ~m_auto;
    end
  endtask

  function automatic logic [4:0] exp_flags();
    return {m_up, m_dn, m_sum, m_auto, m_p[0] | m_p[1] | m_p[2]};
  endfunction

  function automatic logic [7:0] exp_drop8();
    return (m_drops > 255) ? 8'd255 : 8'(m_drops);
  endfunction

  function automatic logic [1:0] exp_drop2();
    return (m_drops > 3) ? 2'd3 : 2'(m_drops);
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs are applied 1 time unit after a rising edge. They are sampled on
  // the next edge. Outputs are read 1 time unit after that edge.
  task automatic do_cycle(input bit u, input bit d, input bit m, input bit t);
    req_up = u; req_dn = d; mode_tgl = m; tick = t;
    @(posedge clk);
    model_step(u, d, m, t);
    #1;
    req_up = 0; req_dn = 0; mode_tgl = 0; tick = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if ({up_en, dn_en, sum_load, auto_on, busy} !== 5'b0 || drop_cnt !== 8'd0 || drop_cnt2 !== 2'd0) begin
      errors++;
      $display("FAIL reset outputs got %b drop %0d/%0d want 00000 drop 0",
               {up_en, dn_en, sum_load, auto_on, busy}, drop_cnt, drop_cnt2);
    end
  endtask

  task automatic test_single();
    logic [4:0] want[4];
    want[0] = 5'b10000; want[1] = 5'b00100; want[2] = 5'b00000; want[3] = 5'b00000;
    do_reset();
    repeat (4) do_cycle(0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      do_cycle(c == 0, 0, 0, 0);
      checks++;
      if ({up_en, dn_en, sum_load, auto_on, busy} !== want[c] || drop_cnt !== 8'd0) begin
        errors++;
        $display("FAIL single c%0d got %b drop %0d want %b drop 0", c,
                 {up_en, dn_en, sum_load, auto_on, busy}, drop_cnt, want[c]);
      end
    end
  endtask

  task automatic test_three_way();
    logic [2:0] want[4]; // {up_en, dn_en, busy}
    want[0] = 3'b101; want[1] = 3'b011; want[2] = 3'b100; want[3] = 3'b000;
    do_reset();
    do_cycle(0, 0, 1, 0);
    checks++;
    if (auto_on !== 1'b1) begin
      errors++;
      $display("FAIL three_way auto_on got %b want 1", auto_on);
    end
    for (int c = 0; c < 4; c++) begin
      do_cycle(c == 0, c == 0, 0, c == 0);
      checks++;
      if ({up_en, dn_en, busy} !== want[c]) begin
        errors++;
        $display("FAIL three_way c%0d got %b want %b", c, {up_en, dn_en, busy}, want[c]);
      end
    end
    // The next auto step must go to the down counter.
    do_cycle(0, 0, 0, 1);
    checks++;
    if ({up_en, dn_en} !== 2'b01) begin
      errors++;
      $display("FAIL three_way dir got %b want 01", {up_en, dn_en});
    end
  endtask

  task automatic test_rr_drop();
    int ups, dns;
    ups = 0; dns = 0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      do_cycle(c < 3, c == 0, 0, 0);
      ups += up_en; dns += dn_en;
      checks++;
      if ({up_en, dn_en, sum_load, auto_on, busy} !== exp_flags() || drop_cnt !== exp_drop8()) begin
        errors++;
        $display("FAIL rr_seq c%0d got %b drop %0d want %b drop %0d", c,
                 {up_en, dn_en, sum_load, auto_on, busy}, drop_cnt, exp_flags(), exp_drop8());
      end
    end
    checks++;
    if (ups !== 3 || dns !== 1 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rr_counts got up %0d dn %0d drop %0d want 3 1 0", ups, dns, drop_cnt);
    end
    // Conflicting up+dn pulses: the third pair loses an up request.
    for (int c = 0; c < 3; c++) do_cycle(1, 1, 0, 0);
    checks++;
    if (drop_cnt !== 8'd1 || drop_cnt2 !== 2'd1) begin
      errors++;
      $display("FAIL rr_drop got %0d/%0d want 1", drop_cnt, drop_cnt2);
    end
  endtask

  task automatic test_auto_alternate();
    int seen;
    seen = 0;
    exp_q.delete();
    do_reset();
    do_cycle(0, 0, 1, 0);
    for (int k = 0; k < 4; k++) exp_q.push_back((k % 2 == 0) ? 2'b10 : 2'b01);
    for (int c = 0; c < 16; c++) begin
      do_cycle(0, 0, 0, (c % 4) == 0);
      if (up_en || dn_en) begin
        checks++;
        if (exp_q.size() == 0 || {up_en, dn_en} !== exp_q[0]) begin
          errors++;
          $display("FAIL auto_alt step got %b want %b", {up_en, dn_en},
                   (exp_q.size() == 0) ? 2'b00 : exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        seen++;
      end
    end
    checks++;
    if (seen !== 4 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL auto_alt count got %0d want 4", seen);
    end
    do_cycle(0, 0, 1, 0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      do_cycle(0, 0, 0, (c % 4) == 0);
      seen += up_en + dn_en;
    end
    checks++;
    if (seen !== 0 || auto_on !== 1'b0) begin
      errors++;
      $display("FAIL manual_ticks got en %0d auto_on %b want 0 0", seen, auto_on);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int c = 0; c < 20; c++) do_cycle(1, 1, 0, 0);
    checks++;
    if (drop_cnt2 !== 2'd3) begin
      errors++;
      $display("FAIL saturate2 got %0d want 3", drop_cnt2);
    end
    checks++;
    if (drop_cnt !== exp_drop8() || drop_cnt <= 8'd3) begin
      errors++;
      $display("FAIL drop8 got %0d want %0d", drop_cnt, exp_drop8());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    do_cycle(0, 0, 1, 0);
    for (int c = 0; c < 3; c++) do_cycle(1, 1, 0, 1);
    checks++;
    if (up_en !== 1'b1 || busy !== 1'b1 || {m_p[0], m_p[1], m_p[2]} !== 3'b111) begin
      errors++;
      $display("FAIL pre_reset got up_en %b busy %b want 1 1", up_en, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({up_en, dn_en, sum_load, auto_on, busy} !== 5'b0 || drop_cnt !== 8'd0 ||
        {up_en2, dn_en2, sum_load2, auto_on2, busy2} !== 5'b0 || drop_cnt2 !== 2'd0) begin
      errors++;
      $display("FAIL async_reset got %b drop %0d want 00000 drop 0",
               {up_en, dn_en, sum_load, auto_on, busy}, drop_cnt);
    end
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_cycle(0, 1, 0, 0);
    checks++;
    if ({up_en, dn_en, sum_load, busy} !== 4'b0100) begin
      errors++;
      $display("FAIL after_reset got %b want 0100", {up_en, dn_en, sum_load, busy});
    end
  endtask

  task automatic test_random();
    bit u, d, m, t;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      u = ($urandom_range(0, 99) < 40);
      d = ($urandom_range(0, 99) < 40);
      m = ($urandom_range(0, 99) < 6);
      t = ($urandom_range(0, 99) < 50);
      do_cycle(u, d, m, t);
      checks++;
      if ({up_en, dn_en, sum_load, auto_on, busy} !== exp_flags() ||
          drop_cnt !== exp_drop8() || drop_cnt2 !== exp_drop2() ||
          {up_en2, dn_en2, sum_load2, auto_on2, busy2} !== exp_flags()) begin
        errors++;
        $display("FAIL random c%0d got %b drop %0d/%0d want %b drop %0d/%0d", c,
                 {up_en, dn_en, sum_load, auto_on, busy}, drop_cnt, drop_cnt2,
                 exp_flags(), exp_drop8(), exp_drop2());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req_up = 0; req_dn = 0; mode_tgl = 0; tick = 0;
    model_reset();
    test_reset();
    test_single();
    test_three_way();
    test_rr_drop();
    test_auto_alternate();
    test_saturate();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_arbiter.md
# step_arbiter

Scheduler for the shared counter bank of the Supercar display datapath: the up counter (HEX1), the down counter (HEX2) and the sum register (HEX3).
- Accepts step requests from two key edge pulses and from an internal auto-step source driven by a prescaler tick.
- Arbitrates them round-robin into at most one counter step per cycle, buffering one pending request per requester.
- Strobes the sum register after every step so HEX3 always reflects a settled counter pair.

## Interface
Parameters:
- DROP_W, default 8: width of the saturating dropped-request counter.

Ports:
- clk, input, 1: system clock (CLOCK_50 domain).
- rst, input, 1: asynchronous, active-high reset.
- req_up, input, 1: one-cycle pulse requesting one up-counter step (key 1 edge trigger).
- req_dn, input, 1: one-cycle pulse requesting one down-counter step (key 2 edge trigger).
- mode_tgl, input, 1: one-cycle pulse that toggles MANUAL/AUTO (key 3 edge trigger).
- tick, input, 1: one-cycle prescaler pulse; it is the auto-step source in AUTO mode.
- up_en, output, 1: registered one-cycle enable to the up counter.
- dn_en, output, 1: registered one-cycle enable to the down counter.
- sum_load, output, 1: registered one-cycle load strobe for the sum register.
- auto_on, output, 1: high while in AUTO state.
- busy, output, 1: high while any pending flag is set.
- drop_cnt, output, DROP_W: saturating count of lost requests.

## Operation
- Requesters, in index order: 0 = up (req_up), 1 = dn (req_dn), 2 = auto (tick, valid only in AUTO).
- Each requester has a pending flag p[i]. Effective request: e[i] = p[i] | new[i].
- Arbitration:
  - Combinational round-robin over e[], starting at pointer rr.
  - At most one grant per cycle.
  - After a grant, rr = granted index + 1 (mod 3).
  - rr is unchanged when there is no grant.
- Grant mapping:
  - Up grant sets up_en on the next cycle.
  - Dn grant sets dn_en on the next cycle.
  - Auto grant sets up_en if auto_dir = 0, else dn_en; auto_dir then toggles.
- up_en and dn_en are never high together.
- Pending update per requester, each cycle:
  - Granted with p=1 and new=1: p stays 1.
  - Granted otherwise: p cleared.
  - Not granted: p = e.
  - Not granted with p=1 and new=1: the new request is dropped and drop_cnt increments.
  - drop_cnt saturates at 2^DROP_W-1.
- Mode FSM, states MANUAL (reset) and AUTO:
  - mode_tgl toggles the state.
  - On AUTO to MANUAL, p[2] is cleared. An auto grant made in that same cycle still completes.
  - In MANUAL, tick is ignored.
  - On entering AUTO, auto_dir is preserved.
- sum_load is asserted the cycle after each up_en or dn_en cycle, when the updated count is visible at the adder input.
- busy = p[0] | p[1] | p[2]. auto_on = (state == AUTO).
- Reset values:
  - up_en, dn_en, sum_load, busy = 0.
  - auto_on = 0 (MANUAL).
  - drop_cnt = 0, rr = 0, auto_dir = 0, all p = 0.
- Reset mid-operation: all pending requests and in-flight enable/load pulses are discarded immediately (asynchronous).

## Timing
- Uncontested request in cycle n: enable high in cycle n+1, sum_load high in cycle n+2.
- Throughput: one step per cycle. Back-to-back grants produce back-to-back enables and overlapping sum_load pulses.
- Worst case: a request waits at most 2 cycles behind the other requesters.
- Simultaneous events:
  - mode_tgl and tick in the same cycle while in MANUAL: the tick is ignored (the FSM state sampled is the current one).
  - mode_tgl and tick in the same cycle while in AUTO: the tick is accepted, then p[2] is cleared if not granted.
- After rst deasserts, requests are honoured starting the first clock edge.

## Test plan
- Reset then a single req_up pulse at cycle 5: up_en = 1 only in cycle 6, sum_load = 1 only in cycle 7, busy stays 0, drop_cnt = 0.
- req_up, req_dn and tick (AUTO, auto_dir = 0) all in cycle 5, rr = 0:
  - up_en in cycle 6, dn_en in cycle 7 (dn request), up_en in cycle 8 (auto step), then auto_dir = 1.
  - busy high in cycles 6-7.
- req_up in cycles 5, 6 and 7 while req_dn is also pulsed in 5: three up_en and one dn_en, interleaved per round-robin, no drop.
  - Then a fourth req_up while p[0] = 1 and not granted: drop_cnt = 1.
- AUTO with tick every 4 cycles for 4 ticks: enables alternate up, dn, up, dn. mode_tgl then returns to MANUAL: further ticks produce no enables, auto_on = 0.
- Continuous conflicting req_up pulses to force drops with DROP_W = 2: drop_cnt saturates at 3.
- rst asserted asynchronously between clock edges while p = 3'b111 and up_en = 1: all outputs 0 immediately. After release, one req_dn gives dn_en one cycle later.
